// File: rtl/prf_fre_lst.sv
// Physical register free list: circular buffer with speculative head, committed head and tail.
// Zero-cycle allocate, all-or-nothing grant (alc_gnt low stalls the whole group); frees are always accepted.
module prf_fre_lst #(
   parameter  int PREG_NUM = 64,
   parameter  int ARCH_NUM = 16,
   parameter  int WAY      = 4,
   localparam int IW       = $clog2(PREG_NUM),
   localparam int PW       = IW + 1,
   localparam int CW       = $clog2(WAY + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WAY-1:0]    alc_req,
   output logic              alc_gnt,
   output logic [WAY*IW-1:0] alc_preg,
   input  logic [WAY-1:0]    fre_vld,
   input  logic [WAY*IW-1:0] fre_preg,
   input  logic [CW-1:0]     cmt_cnt,
   input  logic              flush,
   output logic [PW-1:0]     fre_cnt
);

   logic [IW-1:0] ent [PREG_NUM];
   logic [PW-1:0] hd;
   logic [PW-1:0] cmt_hd;
   logic [PW-1:0] tl;

   logic [CW-1:0] alc_n;
   logic [CW-1:0] fre_n;
   logic [PW-1:0] alc_ptr [WAY];
   logic [PW-1:0] fre_ptr [WAY];

   assign fre_cnt = tl - hd;
   assign alc_gnt = !flush && (PW'(alc_n) <= fre_cnt);

   // Prefix counts compact the sparse request/free masks onto consecutive entries.
   always_comb begin
      logic [CW-1:0] a_acc;
      logic [CW-1:0] f_acc;
      a_acc = '0;
      f_acc = '0;
      for (int i = 0; i < WAY; i++) begin
         alc_ptr[i] = hd + PW'(a_acc);
         fre_ptr[i] = tl + PW'(f_acc);
         a_acc      = a_acc + CW'(alc_req[i]);
         f_acc      = f_acc + CW'(fre_vld[i]);
      end
      alc_n = a_acc;
      fre_n = f_acc;
   end

   always_comb begin
      alc_preg = '0;
      for (int i = 0; i < WAY; i++) begin
         if (alc_gnt && alc_req[i]) begin
            alc_preg[i*IW +: IW] = ent[alc_ptr[i][IW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hd     <= '0;
         cmt_hd <= '0;
         tl     <= PW'(PREG_NUM - ARCH_NUM);
         for (int i = 0; i < PREG_NUM; i++) begin
            ent[i] <= (i < PREG_NUM - ARCH_NUM) ? IW'(ARCH_NUM + i) : '0;
         end
      end else begin
         for (int i = 0; i < WAY; i++) begin
            if (fre_vld[i]) begin
               ent[fre_ptr[i][IW-1:0]] <= fre_preg[i*IW +: IW];
            end
         end
         tl     <= tl + PW'(fre_n);
         cmt_hd <= cmt_hd + PW'(cmt_cnt);
         // Flush rolls the speculative head back to the post-commit point.
         if (flush) begin
            hd <= cmt_hd + PW'(cmt_cnt);
         end else if (alc_gnt) begin
            hd <= hd + PW'(alc_n);
         end
      end
   end

endmodule

// File: tb/tb_prf_fre_lst.sv
// Bench for prf_fre_lst: directed vector table, hand sequences and a queue-model scoreboard.
module tb_prf_fre_lst;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  alc_req;
   logic        alc_gnt;
   logic [23:0] alc_preg;
   logic [3:0]  fre_vld;
   logic [23:0] fre_preg;
   logic [2:0]  cmt_cnt;
   logic        flush;
   logic [6:0]  fre_cnt;

   always #5 clk = ~clk;

   prf_fre_lst dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .alc_req  (alc_req),
      .alc_gnt  (alc_gnt),
      .alc_preg (alc_preg),
      .fre_vld  (fre_vld),
      .fre_preg (fre_preg),
      .cmt_cnt  (cmt_cnt),
      .flush    (flush),
      .fre_cnt  (fre_cnt)
   );

   typedef struct {
      logic        gnt;
      logic [23:0] preg;
      int          cnt;
   } exp_t;

   typedef struct {
      bit          rst;
      logic [3:0]  req;
      logic [3:0]  fv;
      logic [23:0] fp;
      logic [2:0]  cc;
      logic        fl;
      logic        gnt;
      logic [23:0] preg;
      logic [6:0]  cnt;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   // Model: fl holds pregs from committed head to tail; the first spec are speculatively allocated.
   int fl[$];
   int spec;
   int arch[$];
   int retq[$];

   function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
      return {6'(d), 6'(c), 6'(b), 6'(a)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic model_reset();
      fl.delete(); arch.delete(); retq.delete();
      spec = 0;
      for (int i = 0; i < 48; i++) fl.push_back(16 + i);
      for (int i = 0; i < 16; i++) arch.push_back(i);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; alc_req = '0; fre_vld = '0; fre_preg = '0; cmt_cnt = '0; flush = 1'b0;
      @(negedge clk);
      chk("rst_cnt", 32'(fre_cnt), 32'd48);
      chk("rst_gnt", 32'(alc_gnt), 32'd1);
      chk("rst_preg", 32'(alc_preg), 32'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic step(input logic [3:0] req, input logic [3:0] fv, input logic [23:0] fp,
                       input logic [2:0] cc, input logic fl_i,
                       output logic g, output logic [23:0] p, output logic [6:0] c);
      exp_t e;
      int   n, cnt, k, mc;
      @(posedge clk); #1;
      alc_req = req; fre_vld = fv; fre_preg = fp; cmt_cnt = cc; flush = fl_i;
      n   = $countones(req);
      cnt = fl.size() - spec;
      mc  = (spec < 4) ? spec : 4;
      if (int'(cc) > mc) begin
         failures++;
         $display("FAIL illegal_commit cmt_cnt=%0d required<=%0d", cc, mc);
      end
      e.gnt  = !fl_i && (n <= cnt);
      e.preg = '0;
      e.cnt  = cnt;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         if (req[i]) begin
            if (e.gnt) e.preg[i*6 +: 6] = 6'(fl[spec + k]);
            k++;
         end
      end
      sbq.push_back(e);
      if (e.gnt) spec += n;
      for (int j = 0; j < int'(cc); j++) begin
         if (fl.size() > 0) begin
            arch.push_back(fl.pop_front());
            retq.push_back(arch.pop_front());
            if (spec > 0) spec--;
         end
      end
      if (fl_i) spec = 0;
      for (int i = 0; i < 4; i++) if (fv[i]) fl.push_back(int'(fp[i*6 +: 6]));
      if (fl.size() - spec > 48) begin
         failures++;
         $display("FAIL illegal_free free_count=%0d required<=48", fl.size() - spec);
      end
      @(negedge clk);
      e = sbq.pop_front();
      chk("sb_gnt", 32'(alc_gnt), 32'(e.gnt));
      chk("sb_preg", 32'(alc_preg), 32'(e.preg));
      chk("sb_cnt", 32'(fre_cnt), 32'(e.cnt));
      g = alc_gnt; p = alc_preg; c = fre_cnt;
   endtask

   initial begin
      logic        g;
      logic [23:0] p;
      logic [6:0]  c;
      logic [3:0]  fv;
      logic [23:0] fp;
      int          mc;

      rst_n = 1'b0; alc_req = '0; fre_vld = '0; fre_preg = '0; cmt_cnt = '0; flush = 1'b0;

      // rst, req, fv, fp, cc, flush | gnt, preg, fre_cnt
      tbl.push_back(vec_t'{1, 4'hF, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(16, 17, 18, 19), 7'd48});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, 24'h0, 7'd44});
      tbl.push_back(vec_t'{1, 4'hA, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(0, 16, 0, 17), 7'd48});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, 24'h0, 7'd46});
      tbl.push_back(vec_t'{1, 4'hF, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(16, 17, 18, 19), 7'd48});
      tbl.push_back(vec_t'{0, 4'hF, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(20, 21, 22, 23), 7'd44});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd2, 1'b0, 1'b1, 24'h0, 7'd40});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd0, 1'b1, 1'b0, 24'h0, 7'd40});
      tbl.push_back(vec_t'{0, 4'h1, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(18, 0, 0, 0), 7'd46});
      tbl.push_back(vec_t'{1, 4'hF, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(16, 17, 18, 19), 7'd48});
      tbl.push_back(vec_t'{0, 4'hF, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, pk(20, 21, 22, 23), 7'd44});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd2, 1'b0, 1'b1, 24'h0, 7'd40});
      tbl.push_back(vec_t'{0, 4'h3, 4'h1, pk(7, 0, 0, 0), 3'd0, 1'b1, 1'b0, 24'h0, 7'd40});
      tbl.push_back(vec_t'{0, 4'h0, 4'h0, 24'h0, 3'd0, 1'b0, 1'b1, 24'h0, 7'd47});

      foreach (tbl[v]) begin
         if (tbl[v].rst) do_reset();
         step(tbl[v].req, tbl[v].fv, tbl[v].fp, tbl[v].cc, tbl[v].fl, g, p, c);
         chk($sformatf("tbl%0d_gnt", v), 32'(g), 32'(tbl[v].gnt));
         chk($sformatf("tbl%0d_preg", v), 32'(p), 32'(tbl[v].preg));
         chk($sformatf("tbl%0d_cnt", v), 32'(c), 32'(tbl[v].cnt));
      end

      // Exhaustion, then a same-cycle free that becomes visible one cycle later.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(4'hF, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
         chk("exh_preg", 32'(p), 32'(pk(16 + 4*i, 17 + 4*i, 18 + 4*i, 19 + 4*i)));
      end
      step(4'h1, 4'h1, pk(5, 0, 0, 0), 3'd0, 1'b0, g, p, c);
      chk("exh_deny_gnt", 32'(g), 32'd0);
      chk("exh_deny_cnt", 32'(c), 32'd0);
      chk("exh_deny_preg", 32'(p), 32'd0);
      step(4'h1, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
      chk("exh_regrant_gnt", 32'(g), 32'd1);
      chk("exh_regrant_preg", 32'(p), 32'd5);

      // Tail wraps 62 -> 2 on a 4-wide free; allocations then straddle index 63 -> 0.
      do_reset();
      for (int i = 0; i < 6; i++) step(4'hF, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
      for (int i = 0; i < 6; i++) step(4'h0, 4'h0, 24'h0, 3'd4, 1'b0, g, p, c);
      step(4'h0, 4'hF, pk(16, 17, 18, 19), 3'd0, 1'b0, g, p, c);
      step(4'h0, 4'hF, pk(20, 21, 22, 23), 3'd0, 1'b0, g, p, c);
      step(4'h0, 4'hF, pk(24, 25, 26, 27), 3'd0, 1'b0, g, p, c);
      step(4'h0, 4'h3, pk(28, 29, 0, 0), 3'd0, 1'b0, g, p, c);
      step(4'h0, 4'hF, pk(30, 31, 32, 33), 3'd0, 1'b0, g, p, c);
      for (int i = 0; i < 9; i++) begin
         step(4'hF, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
         if (i == 0) chk("wrap_cnt", 32'(c), 32'd42);
      end
      step(4'h3, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
      chk("wrap_pre_preg", 32'(p), 32'(pk(28, 29, 0, 0)));
      step(4'hF, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
      chk("wrap_cross_gnt", 32'(g), 32'd1);
      chk("wrap_cross_preg", 32'(p), 32'(pk(30, 31, 32, 33)));
      step(4'h0, 4'h0, 24'h0, 3'd0, 1'b0, g, p, c);
      chk("wrap_empty_cnt", 32'(c), 32'd0);

      // Random traffic against the model, with one reset asserted mid-operation.
      do_reset();
      for (int t = 0; t < 400; t++) begin
         if (t == 200) begin
            @(posedge clk); #1;
            alc_req = 4'hF; fre_vld = 4'hF; fre_preg = $urandom; cmt_cnt = 3'd1; flush = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst_cnt", 32'(fre_cnt), 32'd48);
            chk("midrst_preg", 32'(alc_preg), 32'(pk(16, 17, 18, 19)));
            rst_n = 1'b1;
            alc_req = '0; fre_vld = '0; cmt_cnt = '0;
            model_reset();
         end
         fp = $urandom;
         fv = '0;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1 && retq.size() > 0) begin
               fv[i] = 1'b1;
               fp[i*6 +: 6] = 6'(retq.pop_front());
            end
         end
         mc = (spec < 4) ? spec : 4;
         step(4'($urandom), fv, fp, 3'($urandom_range(0, mc)),
              ($urandom_range(0, 19) == 0), g, p, c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prf_fre_lst.md
PRF_FRE_LST -- requirements
Module: prf_fre_lst

Interface
REQ-001 SHALL have parameter PREG_NUM, default 64, giving the number of physical registers (6-bit preg id).
REQ-002 SHALL have parameter ARCH_NUM, default 16, giving the number of logical registers mapped at reset.
REQ-003 SHALL have parameter WAY, default 4, giving the allocate, free and commit width per cycle.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port alc_req, input, 4 bits: bit i set means decode slot i needs a destination preg.
REQ-007 SHALL have port alc_gnt, output, 1 bit: all requested slots are served this cycle.
REQ-008 SHALL have port alc_preg, output, 24 bits: slot i preg id in bits [6i+5:6i].
REQ-009 SHALL have port fre_vld, input, 4 bits: bit i set means commit slot i returns a preg.
REQ-010 SHALL have port fre_preg, input, 24 bits: the returned preg ids, packed as in alc_preg.
REQ-011 SHALL have port cmt_cnt, input, 3 bits: number of allocations retired this cycle, range 0-4.
REQ-012 SHALL have port flush, input, 1 bit: mispredict or exception recovery.
REQ-013 SHALL have port fre_cnt, output, 7 bits: number of free pregs currently in the list.

Function
REQ-014 SHALL store the free list as a circular buffer of PREG_NUM 6-bit entries.
REQ-015 SHALL keep three 7-bit pointers: hd (speculative head), cmt_hd (committed head) and tl (tail); the buffer index is pointer[5:0], and each pointer wraps modulo 128.
REQ-016 SHALL drive fre_cnt = tl - hd as a 7-bit value, directly from registers.
REQ-017 SHALL let n = popcount(alc_req).
REQ-018 SHALL assert alc_gnt combinationally when n <= fre_cnt and flush = 0; alc_req = 0 also gives alc_gnt = 1.
REQ-019 SHALL serve set bits of alc_req in ascending slot order: the k-th set bit receives entry[(hd + k) mod 64], for k = 0..n-1.
REQ-020 SHALL drive the alc_preg field of an unrequested slot to 0; when alc_gnt = 0, every field SHALL be 0.
REQ-021 SHALL advance hd by n at the clock edge when alc_gnt = 1; otherwise hd is unchanged (all-or-nothing, no partial grant).
REQ-022 SHALL write the set bits of fre_vld, compacted in ascending order, into entry[(tl + k) mod 64], and advance tl by popcount(fre_vld).
REQ-023 SHALL make same-cycle frees visible to allocation only from the next cycle (no bypass).
REQ-024 SHALL advance cmt_hd by cmt_cnt each cycle.
REQ-025 SHALL, on flush, load hd with cmt_hd + cmt_cnt, reclaiming every speculative allocation.
REQ-026 SHALL still apply the frees and the commit that occur in the same cycle as a flush.
REQ-027 SHALL deny allocation in the flush cycle (flush has priority over allocation).
REQ-028 SHALL let allocation and free in the same cycle both take effect: fre_cnt_next = fre_cnt - n*alc_gnt + popcount(fre_vld).
REQ-029 SHALL treat as illegal any cmt_cnt > 4, any commit that overtakes hd, and any free that takes fre_cnt above PREG_NUM - ARCH_NUM; the bench SHALL assert on each.
REQ-030 SHALL have zero-cycle allocate latency, with state updated on the next rising edge.

Reset
REQ-031 SHALL, on rst_n low, set entry[i] = ARCH_NUM + i for i = 0..47, hd = 0, cmt_hd = 0 and tl = 48.
REQ-032 SHALL therefore give fre_cnt = 48 and alc_gnt = 1 while alc_req = 0 during reset.
REQ-033 SHALL leave entries 48..63 don't-care at reset.
REQ-034 SHALL apply a reset asserted mid-operation immediately, discarding all in-flight allocate, free and commit activity.

Verification
REQ-035 SHALL cover: after reset, alc_req = 4'b1111 -> alc_gnt = 1, alc_preg = {19,18,17,16}; the next cycle fre_cnt = 44.
REQ-036 SHALL cover: after reset, alc_req = 4'b1010 -> slot1 = 16, slot3 = 17, slots 0 and 2 = 0; fre_cnt = 46 the next cycle.
REQ-037 SHALL cover exhaustion: 12 cycles of 4'b1111, then alc_req = 4'b0001 -> alc_gnt = 0, fre_cnt = 0, hd unchanged; in the same cycle free preg 5 -> the next cycle alc_req = 4'b0001 grants 5.
REQ-038 SHALL cover wrap: cycle enough allocations and frees that tl[5:0] goes 62 -> 2 on a 4-wide free; later allocations return those pregs in order across index 63 -> 0.
REQ-039 SHALL cover flush: allocate 16..23 over 2 cycles, cmt_cnt = 2 for one cycle, then flush -> fre_cnt = 46 the next cycle and the next single allocation returns 18.
REQ-040 SHALL cover flush with alc_req = 4'b0011 and fre_vld = 4'b0001 (preg 7) in the same cycle -> alc_gnt = 0, and the free is retained (fre_cnt +1 versus the flush-only case).
